// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between the execute stage and muldiv_unit.
//   start   : request, taken only while the unit is not busy
//   funct3  : M-op select (MUL..REMU)
//   op_a    : rs1 / dividend / multiplicand
//   op_b    : rs2 / divisor / multiplier
//   kill    : abort the op in flight (pipeline flush)
//   busy    : op in flight, start ignored
//   done    : one-cycle pulse, result valid
//   result  : selected result, held until the next op completes
// master drives the request side; slave is the execute unit.
// ---------------------------------------------------------------------------
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M/RV64M execute unit: radix-2 shift-add multiply and
// restoring divide, one iteration per clock, with start/done handshake.
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : muldiv_if.slave (start, funct3, op_a, op_b, kill,
//              busy, done, result)
//
// Optional build macro MULDIV_FAST_MUL_EN: when defined, the four
// multiply ops use a combinational multiplier and finish one edge after
// accept; divide stays iterative. When undefined no multiplier is built.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_iter;
    logic              w_finish;
    logic              w_busy;
    logic              w_done;

    op_t               r_op;
    logic              r_neg;
    logic              r_special;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_result;

    // ---------------- request decode ----------------
    op_t               w_op;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg;
    logic [XLEN-1:0]   w_min;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;

    assign w_op       = op_t'(bus.funct3);
    assign w_is_div   = bus.funct3[2];
    assign w_a_signed = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign w_b_signed = (w_op inside {OP_MULH, OP_DIV, OP_REM});
    assign w_sa       = w_a_signed & bus.op_a[XLEN-1];
    assign w_sb       = w_b_signed & bus.op_b[XLEN-1];
    assign w_mag_a    = w_sa ? -bus.op_a : bus.op_a;
    assign w_mag_b    = w_sb ? -bus.op_b : bus.op_b;
    // Remainder takes the dividend's sign; product and quotient the XOR.
    assign w_neg      = (w_op inside {OP_REM, OP_REMU}) ? w_sa : (w_sa ^ w_sb);

    assign w_min      = {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0     = w_is_div && (bus.op_b == '0);
    assign w_ovf      = (w_op inside {OP_DIV, OP_REM}) &&
                        (bus.op_a == w_min) && (bus.op_b == '1);
    assign w_special  = w_div0 | w_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign w_spec_res = w_div0 ? (bus.funct3[1] ? bus.op_a : '1)
                               : (bus.funct3[1] ? '0 : bus.op_a);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;

    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift {carry, hi, lo} right by one.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Divide: shift {rem, quo} left, trial-subtract divisor; bit XLEN of
    // the difference is the borrow.
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    // ---------------- final select / sign fix ----------------
    logic [2*XLEN-1:0] w_raw;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_raw  = {r_hi, r_lo};
    assign w_prod = r_neg ? -w_raw : w_raw;
    assign w_quo  = r_neg ? -r_lo : r_lo;
    assign w_rem  = r_neg ? -r_hi : r_hi;

    always_comb begin
        w_final = '0;
        if (r_special) begin
            w_final = r_lo;
        end else begin
            case (r_op)
                OP_MUL:                        w_final = w_prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:               w_final = w_quo;
                OP_REM, OP_REMU:               w_final = w_rem;
                default:                       w_final = '0;
            endcase
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Special cases (and fast multiplies) load a zero count so they spend
    // exactly one CALC cycle resolving before FIX, with no iteration.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_iter   = 1'b0;
        w_finish = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE, S_FIX: begin
                // done is suppressed if the op is being flushed this cycle.
                w_done = (r_state == S_FIX) && !bus.kill;
                if (bus.kill) begin
                    w_next = S_IDLE;
                end else if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (bus.kill) begin
                    w_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_finish = 1'b1;
                    w_next   = S_FIX;
                end else begin
                    w_iter = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= OP_MUL;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= w_op;
                r_neg     <= w_neg;
                r_special <= w_special;
                if (w_special) begin
                    r_hi  <= '0;
                    r_lo  <= w_spec_res;
                    r_cnt <= '0;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!w_is_div) begin
                    r_hi  <= w_fast_prod[2*XLEN-1:XLEN];
                    r_lo  <= w_fast_prod[XLEN-1:0];
                    r_cnt <= '0;
                end
`endif
                else begin
                    r_hi  <= '0;
                    r_cnt <= CNT_W'(XLEN);
                    if (w_is_div) begin
                        r_lo <= w_mag_a;
                        r_b  <= w_mag_b;
                    end else begin
                        r_lo <= w_mag_b;
                        r_b  <= w_mag_a;
                    end
                end
            end else if (w_iter) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_op[2]) begin
                    if (!w_diff[XLEN]) begin
                        r_hi <= w_diff[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        r_hi <= w_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    r_hi <= w_sum[XLEN:1];
                    r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                end
            end else if (w_finish) begin
                r_result <= w_final;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table,
// randomized ops against an arithmetic reference model, and hand-written
// kill / held-start / mid-op reset sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic reset_n;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: plain 64-bit / 32-bit arithmetic on the M-op rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub;          return p[31:0];  end
            3'd1: begin p = sa * sb;          return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;          return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return 32'(int'($signed(a)) / int'($signed(b)));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return 32'(int'($signed(a)) % int'($signed(b)));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_LAT;
    endfunction

    // Issues an op immediately (caller is idle or in the done cycle) and
    // returns the result and the number of edges after accept until done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                res = bus.result;
                break;
            end
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] res;
        logic [31:0] last_res;
        int          lat;
        int          dones;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'h0000_000E, DIV_LAT};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'h0000_0002, DIV_LAT};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'h0000_0005, 1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT};
        vecs[13] = '{3'd7, 32'd7,          32'd0,         32'h0000_0007, 1};

        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = '0;
        bus.op_b   = '0;

        // Reset state
        #3;
        check("reset_busy",   {31'b0, bus.busy}, 32'd0);
        check("reset_done",   {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result,        32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table; consecutive ops issue in the done cycle.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'($urandom_range(1, 5)) ^ {32{b[31]}};
                default: ;
            endcase
            run_op(f3, a, b, res, lat);
            check($sformatf("rnd%0d_f%0d_res", i, f3), res, ref_model(f3, a, b));
            check($sformatf("rnd%0d_f%0d_lat", i, f3), 32'(lat), 32'(ref_lat(f3, a, b)));
        end
        last_res = ref_model(f3, a, b);

        // kill mid-DIVU: busy drops at the next edge, no done, result held
        @(negedge clk);
        bus.funct3 = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check("kill_busy", {31'b0, bus.busy}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("kill_no_done", 32'(dones), 32'd0);
        check("kill_result_held", bus.result, last_res);

        // start held high through busy: one accept, one done
        @(negedge clk);
        bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                res = bus.result;
                bus.start = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        check("held_lat", 32'(lat), 32'(DIV_LAT));
        check("held_res", res, 32'h0000_000E);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("held_single_done", 32'(dones), 32'd0);

        // Asynchronous reset mid-MUL clears outputs immediately
        @(negedge clk);
        bus.funct3 = 3'd0; bus.op_a = 32'd7; bus.op_b = 32'hFFFF_FFFD; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_busy",   {31'b0, bus.busy}, 32'd0);
        check("rst_mid_done",   {31'b0, bus.done}, 32'd0);
        check("rst_mid_result", bus.result,        32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat);
        check("post_rst_res", res, 32'hFFFF_FFEB);
        check("post_rst_lat", 32'(lat), 32'(MUL_LAT));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
